// File: rtl/serial_deframer.sv
// Serial deframer: samples a 1-bit line, finds start/stop framing and
// reassembles NWORDS x WBITS payload words with per-word K flags.
module serial_deframer #(
    parameter int unsigned NWORDS = 3,
    parameter int unsigned WBITS  = 9,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      data_i,
    output logic [NWORDS*WBITS-1:0]   data_o,
    output logic [NWORDS-1:0]         k_o,
    output logic                      valid_o,
    output logic                      frame_err_o,
    output logic                      busy_o,
    output logic [CNT_W-1:0]          frame_cnt_o
);

    localparam int unsigned FRAME_W   = NWORDS * WBITS;
    localparam int unsigned BIT_CNT_W = $clog2(FRAME_W);
    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(FRAME_W - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_STOP
    } state_t;

    state_t               state;
    logic                 din_q;
    logic [BIT_CNT_W-1:0] cnt;
    logic [FRAME_W-1:0]   shreg;

    // The K flag is the top bit of each word.
    function automatic logic [NWORDS-1:0] k_flags(input logic [FRAME_W-1:0] w);
        logic [NWORDS-1:0] k;
        k = '0;
        for (int unsigned i = 0; i < NWORDS; i++) begin
            k[i] = w[i*WBITS + WBITS - 1];
        end
        return k;
    endfunction

    // Input register: the FSM only ever looks at din_q.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            din_q <= 1'b0;
        end else begin
            din_q <= data_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= S_IDLE;
            cnt         <= '0;
            shreg       <= '0;
            data_o      <= '0;
            k_o         <= '0;
            valid_o     <= 1'b0;
            frame_err_o <= 1'b0;
            frame_cnt_o <= '0;
        end else begin
            valid_o     <= 1'b0;
            frame_err_o <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (din_q) begin
                        state <= S_SHIFT;
                        cnt   <= '0;
                    end
                end
                S_SHIFT: begin
                    shreg <= {shreg[FRAME_W-2:0], din_q};
                    cnt   <= cnt + BIT_CNT_W'(1);
                    if (cnt == LAST_BIT) begin
                        state <= S_STOP;
                    end
                end
                S_STOP: begin
                    // A 1 here is a bad stop bit, never a new start bit.
                    if (din_q) begin
                        frame_err_o <= 1'b1;
                    end else begin
                        data_o      <= shreg;
                        k_o         <= k_flags(shreg);
                        valid_o     <= 1'b1;
                        frame_cnt_o <= frame_cnt_o + CNT_W'(1);
                    end
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy_o = (state != S_IDLE);

endmodule
